eth_tx_arb: RTL and testbench
=============================

# eth_tx_arb

Round-robin scheduler that shares the single GMII transmit port between the Ethernet transmit engines (ARP, ICMP, UDP). It latches start requests from each engine, issues one start pulse at a time, multiplexes the granted engine's `gmii_tx_en`/`gmii_txd` onto the PHY, and enforces the inter-frame gap. A watchdog recovers the port if an engine never reports done. It sits between the per-protocol `*_tx` engines and the GMII output pins, in the `gmii_tx_clk` domain.

## Interface
- `N_REQ`, 3: number of transmit engines. Index 0 = ARP, 1 = ICMP, 2 = UDP.
- `IFG_CYCLES`, 12: idle cycles forced after each frame (IEEE minimum is 12 byte times).
- `TIMEOUT_CYCLES`, 4096: maximum BUSY duration before forced release.

- `clk`  in  1  GMII transmit clock (`gmii_tx_clk`); the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N_REQ  per-engine transmit request; a one-cycle pulse or a held level, each set cycle latches pending.
- `start`  out  N_REQ  one-cycle start pulse to the granted engine (drives that engine's `tx_start_en`).
- `done`  in  N_REQ  per-engine `tx_done` pulse.
- `src_tx_en`  in  N_REQ  per-engine `gmii_tx_en`.
- `src_txd`  in  8*N_REQ  per-engine `gmii_txd`; engine i occupies bits [8i+7:8i].
- `grant`  out  N_REQ  one-hot owner of the port; all-zero when IDLE.
- `busy`  out  1  high in every state except IDLE.
- `gmii_tx_en`  out  1  registered, multiplexed transmit enable to the PHY.
- `gmii_txd`  out  8  registered, multiplexed transmit data to the PHY.
- `timeout_err`  out  1  one-cycle pulse when the watchdog fires.

## Operation
- Pending register: `pend <= (pend & ~clr) | req`, where `clr` is the one-hot of the engine whose start is issued this cycle. If a new request arrives in the same cycle its start is issued, the set wins and the request stays pending.
- Arbitration uses a round-robin pointer `last`, reset to N_REQ-1. The winner is the first pending index searching upward from `last+1`, with modulo wrap. `last` updates to the winner on leaving IDLE.
- FSM states:
  - IDLE:
    - `grant` = 0.
    - If `pend` is non-zero, latch the winner into `grant` and go to START.
  - START:
    - `start[g]` = 1 for exactly one cycle.
    - `clr` = `grant`.
    - Go to BUSY.
  - BUSY:
    - Wait for `done[g]`.
    - `done` from non-granted engines is ignored.
    - When `done[g]` arrives, go to GAP.
    - When the watchdog count reaches TIMEOUT_CYCLES, pulse `timeout_err` and go to GAP.
  - GAP:
    - Counter runs IFG_CYCLES cycles, then go to IDLE.
    - `grant` is held during GAP so the final registered byte drains.
- Mux:
  - `gmii_tx_en <= |(grant & src_tx_en)`.
  - `gmii_txd <=` the `src_txd` slice selected by `grant`, or 0 when `grant` is 0.
  - Activity from non-granted sources never reaches the PHY.
- Counters:
  - Watchdog is 13 bits and clears on entry to BUSY.
  - Gap counter is `$clog2(IFG_CYCLES+1)` bits.
  - Neither counter wraps: each saturates or exits at its terminal count.
- Reset, including mid-frame, clears all of the following on the next edge: `pend`, `grant`, `start`, `gmii_tx_en`, `gmii_txd`, `timeout_err`, counters and FSM (FSM returns to IDLE). `last` returns to N_REQ-1.

## Timing
- Reset values: every output is 0.
- Request to start: `req[i]` high at edge t, with the FSM IDLE:
  - `pend[i]` = 1 after edge t.
  - START is entered at t+1.
  - `start[i]` is high during the cycle after edge t+1 (2-cycle latency).
- Data path: `gmii_tx_en`/`gmii_txd` lag `src_*` by exactly 1 cycle.
- Turnaround: the next START begins no earlier than IFG_CYCLES+2 cycles after `done[g]` (GAP, then IDLE, then START).
- Simultaneous requests from all three engines, from reset, are granted in the order 0, 1, 2.

## Structure
- Shared package `eth_pkg` holds:
  - state enum `arb_state_t` {IDLE, START, BUSY, GAP}.
  - constant `ETH_IFG` = 12.
  - source indices `SRC_ARP`=0, `SRC_ICMP`=1, `SRC_UDP`=2.
- Sub-module `rr_pick` is combinational: inputs `pend` and `last`, outputs the one-hot winner and a valid flag. It is parameterised by N_REQ.
- Everything else (FSM, pending register, counters, output mux) lives in `eth_tx_arb`.

## Test plan
- Single request: pulse `req[1]`; engine model asserts `src_tx_en` for 64 cycles, then `done[1]`.
  - `start[1]` pulses 2 cycles after `req[1]`.
  - `gmii_tx_en` mirrors `src_tx_en[1]` with 1-cycle delay.
  - `busy` drops IFG_CYCLES+1 cycles after `done[1]`.
- Contention: `req` = 3'b111 in one cycle.
  - Starts occur in order 0, 1, 2.
  - Each start is at least 12 idle `gmii_tx_en` cycles after the previous frame.
  - Then re-request 3'b011: grant goes to 0 first (wrap from `last`=2).
- Isolation: while engine 0 is granted, drive `src_tx_en[2]`=1 and `src_txd[2]`=8'hAA, and pulse `done[2]`.
  - PHY outputs never show 8'hAA.
  - FSM stays in BUSY.
- Re-request collision: pulse `req[0]` in the same cycle as `start[0]`.
  - `pend[0]` remains 1.
  - A second `start[0]` follows after the gap.
- Watchdog: grant engine 2 and never assert `done`.
  - `timeout_err` pulses after 4096 BUSY cycles.
  - FSM passes through GAP to IDLE and serves the next pending request.
- Reset mid-frame: assert `rst` for 1 cycle during BUSY, with 2 requests pending.
  - Next cycle: all outputs are 0 and `pend` is 0.
  - No `start` occurs without new `req`.

Source files
------------

// File: rtl/eth_pkg.sv
// -----------------------------------------------------------------------------
// eth_pkg
// Shared definitions for the Ethernet transmit path.
//   arb_state_t : transmit arbiter FSM states
//   ETH_IFG     : inter-frame gap in byte times
//   SRC_*       : transmit engine indices on the arbiter
// -----------------------------------------------------------------------------
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

    localparam int unsigned ETH_IFG = 12;

    localparam int unsigned SRC_ARP  = 0;
    localparam int unsigned SRC_ICMP = 1;
    localparam int unsigned SRC_UDP  = 2;

endpackage

// File: rtl/eth_tx_arb_if.sv
// -----------------------------------------------------------------------------
// eth_tx_arb_if
// Bundle between the per-protocol transmit engines and the transmit arbiter.
//   req       : engine -> arbiter, transmit request (pulse or level)
//   done      : engine -> arbiter, frame finished
//   src_tx_en : engine -> arbiter, per-engine gmii_tx_en
//   src_txd   : engine -> arbiter, per-engine gmii_txd, engine i at [8i+7:8i]
//   start     : arbiter -> engine, one-cycle start pulse
//   grant     : arbiter -> engine, one-hot port owner
// master = engine side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface eth_tx_arb_if #(
    parameter int unsigned N_REQ = 3
);

    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   done;
    logic [N_REQ-1:0]   src_tx_en;
    logic [8*N_REQ-1:0] src_txd;
    logic [N_REQ-1:0]   start;
    logic [N_REQ-1:0]   grant;

    modport master (
        output req,
        output done,
        output src_tx_en,
        output src_txd,
        input  start,
        input  grant
    );

    modport slave (
        input  req,
        input  done,
        input  src_tx_en,
        input  src_txd,
        output start,
        output grant
    );

endinterface

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches pend upward starting one above
// last, wrapping modulo N_REQ, and returns the first set index.
//   pend   : in,  pending request vector
//   last   : in,  index of the previously served requester
//   winner : out, one-hot winner (zero when nothing pending)
//   valid  : out, a winner exists
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned IdxW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] pend,
    input  logic [IdxW-1:0]  last,
    output logic [N_REQ-1:0] winner,
    output logic             valid
);

    always_comb begin
        logic [IdxW-1:0] idx;
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            idx = IdxW'((int'(last) + k) % int'(N_REQ));
            if (!valid && pend[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_arb.sv
// -----------------------------------------------------------------------------
// eth_tx_arb
// Round-robin owner of the single GMII transmit port. Latches engine requests,
// issues one start pulse at a time, muxes the owner's GMII stream to the PHY
// (one register stage) and forces an inter-frame gap after every frame.
// A watchdog releases the port if the owner never reports done.
//   clk         : in,  gmii_tx_clk
//   rst         : in,  synchronous active-high reset
//   src         : slave side of eth_tx_arb_if (req/done/src_* in, start/grant out)
//   busy        : out, arbiter not idle
//   gmii_tx_en  : out, registered transmit enable to the PHY
//   gmii_txd    : out, registered transmit data to the PHY
//   timeout_err : out, one-cycle pulse when the watchdog releases the port
// -----------------------------------------------------------------------------
module eth_tx_arb
    import eth_pkg::*;
#(
    parameter int unsigned N_REQ          = 3,
    parameter int unsigned IFG_CYCLES     = ETH_IFG,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               rst,
    eth_tx_arb_if.slave        src,
    output logic               busy,
    output logic               gmii_tx_en,
    output logic [7:0]         gmii_txd,
    output logic               timeout_err
);

    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned GapW = $clog2(IFG_CYCLES + 1);
    localparam int unsigned WdW  = 13;

    localparam logic [IdxW-1:0] LAST_RST = IdxW'(N_REQ - 1);
    localparam logic [GapW-1:0] GAP_LAST = GapW'(IFG_CYCLES - 1);
    localparam logic [WdW-1:0]  WD_LAST  = WdW'(TIMEOUT_CYCLES - 1);

    arb_state_t        state_q, state_d;
    logic [N_REQ-1:0]  pend_q;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [N_REQ-1:0]  clr;
    logic [N_REQ-1:0]  start_oh;
    logic [N_REQ-1:0]  winner;
    logic              win_valid;
    logic [IdxW-1:0]   last_q, last_d;
    logic [IdxW-1:0]   win_idx;
    logic [GapW-1:0]   gap_q;
    logic [WdW-1:0]    wdog_q;
    logic              done_g;
    logic              wd_fire;
    logic              timeout_fire;
    logic              timeout_q;
    logic              en_q;
    logic [7:0]        txd_q;
    logic [7:0]        txd_mux;

    rr_pick #(
        .N_REQ (N_REQ),
        .IdxW  (IdxW)
    ) u_pick (
        .pend   (pend_q),
        .last   (last_q),
        .winner (winner),
        .valid  (win_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (winner[i]) win_idx = IdxW'(i);
        end
    end

    // Only the owner's done counts; other engines' done pulses are ignored.
    assign done_g  = |(src.done & grant_q);
    assign wd_fire = (wdog_q == WD_LAST);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        clr          = '0;
        start_oh     = '0;
        timeout_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                if (win_valid) begin
                    grant_d = winner;
                    last_d  = win_idx;
                    state_d = START;
                end
            end
            START: begin
                start_oh = grant_q;
                clr      = grant_q;
                state_d  = BUSY;
            end
            BUSY: begin
                if (done_g) begin
                    state_d = GAP;
                end else if (wd_fire) begin
                    timeout_fire = 1'b1;
                    state_d      = GAP;
                end
            end
            GAP: begin
                // Grant stays through the gap so the last registered byte drains.
                if (gap_q == GAP_LAST) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        txd_mux = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) txd_mux = txd_mux | src.src_txd[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pend_q    <= '0;
            grant_q   <= '0;
            last_q    <= LAST_RST;
            gap_q     <= '0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
            en_q      <= 1'b0;
            txd_q     <= '0;
        end else begin
            state_q   <= state_d;
            // A request in the same cycle as its clear keeps the bit set.
            pend_q    <= (pend_q & ~clr) | src.req;
            grant_q   <= grant_d;
            last_q    <= last_d;
            gap_q     <= (state_q == GAP) ? gap_q + GapW'(1) : '0;
            wdog_q    <= (state_q == BUSY) ? wdog_q + WdW'(1) : '0;
            timeout_q <= timeout_fire;
            en_q      <= |(grant_q & src.src_tx_en);
            txd_q     <= txd_mux;
        end
    end

    assign src.start   = start_oh;
    assign src.grant   = grant_q;
    assign busy        = (state_q != IDLE);
    assign gmii_tx_en  = en_q;
    assign gmii_txd    = txd_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_eth_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_eth_tx_arb
// Self-checking bench for eth_tx_arb. A timestamp-based reference model
// (who owns the port, when it was granted, when its frame ended) predicts
// every output each cycle; engine models answer start pulses with frames.
// -----------------------------------------------------------------------------
module tb_eth_tx_arb;
    import eth_pkg::*;

    localparam int N   = 3;
    localparam int IFG = ETH_IFG;
    localparam int TMO = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic       gmii_tx_en;
    logic [7:0] gmii_txd;
    logic       timeout_err;

    eth_tx_arb_if #(.N_REQ(N)) bus ();

    eth_tx_arb #(
        .N_REQ          (N),
        .IFG_CYCLES     (IFG),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src         (bus),
        .busy        (busy),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_txd    (gmii_txd),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: ownership timeline.
    int         m_owner = -1;
    int         m_last  = N - 1;
    bit [N-1:0] m_pend  = '0;
    longint     m_gcyc  = -10;
    longint     m_ecyc  = -1;
    bit         m_terr  = 1'b0;
    bit         m_en    = 1'b0;
    bit [7:0]   m_txd   = '0;

    task automatic model_edge();
        int         prev;
        bit         was_start;
        bit [N-1:0] np;
        prev      = m_owner;
        was_start = (m_owner >= 0) && (cyc - 1 == m_gcyc);
        if (rst) begin
            m_pend = '0; m_owner = -1; m_last = N - 1; m_terr = 0;
            m_en = 0; m_txd = '0; m_ecyc = -1; m_gcyc = -10;
            return;
        end
        m_en  = (prev >= 0) ? bus.src_tx_en[prev] : 1'b0;
        m_txd = (prev >= 0) ? bus.src_txd[8*prev +: 8] : 8'h00;
        m_terr = 1'b0;
        np = m_pend;
        if (was_start) np[prev] = 1'b0;
        np = np | bus.req;
        if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_last + k) % N;
                if (m_pend[j]) begin
                    m_owner = j; m_last = j; m_gcyc = cyc; m_ecyc = -1;
                    break;
                end
            end
        end else if (m_ecyc >= 0) begin
            if (cyc - m_ecyc >= IFG) m_owner = -1;
        end else if (!was_start) begin
            if (bus.done[m_owner]) begin
                m_ecyc = cyc;
            end else if (cyc - m_gcyc - 1 >= TMO) begin
                m_ecyc = cyc;
                m_terr = 1'b1;
            end
        end
        m_pend = np;
    endtask

    task automatic compare();
        bit [N-1:0] eg;
        bit [N-1:0] es;
        eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        es = (m_owner >= 0 && m_gcyc == cyc) ? eg : '0;
        check("grant", bus.grant, eg);
        check("start", bus.start, es);
        check("busy", busy, m_owner >= 0);
        check("gmii_tx_en", gmii_tx_en, m_en);
        check("gmii_txd", gmii_txd, m_txd);
        check("timeout_err", timeout_err, m_terr);
        check("no_aa_leak", gmii_tx_en && (gmii_txd == 8'hAA), 0);
    endtask

    // Engine models and observation logs.
    int     rem[N];
    bit     done_pend[N];
    bit     stuck[N];
    int     flen = 8;
    bit     noise = 1'b0;
    bit     collide_arm = 1'b0;
    bit     ifg_chk = 1'b0;
    longint last_en_cyc = -100;
    int     start_log[$];
    int     n_timeout = 0;

    task automatic observe();
        for (int i = 0; i < N; i++) begin
            if (bus.start[i]) begin
                if (ifg_chk && start_log.size() > 0)
                    check("ifg_idle", (cyc - last_en_cyc - 1) >= IFG, 1);
                start_log.push_back(i);
            end
        end
        if (gmii_tx_en) last_en_cyc = cyc;
        if (timeout_err) n_timeout++;
    endtask

    task automatic engines();
        logic [N-1:0]   en;
        logic [N-1:0]   dn;
        logic [8*N-1:0] d;
        logic [N-1:0]   rq;
        en = '0; dn = '0; d = '0; rq = '0;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                rem[i] = 0; done_pend[i] = 0;
            end else begin
                if (bus.start[i]) rem[i] = (flen > 0) ? flen : $urandom_range(1, 40);
                if (rem[i] > 0) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    if (b == 8'hAA) b = 8'h55;
                    en[i] = 1'b1;
                    d[8*i +: 8] = b;
                    rem[i]--;
                    if (rem[i] == 0 && !stuck[i]) done_pend[i] = 1'b1;
                end else if (done_pend[i]) begin
                    dn[i] = 1'b1;
                    done_pend[i] = 1'b0;
                end else if (noise && m_owner != i) begin
                    en[i] = 1'($urandom);
                    d[8*i +: 8] = 8'hAA;
                    dn[i] = ($urandom_range(0, 15) == 0);
                end
            end
        end
        if (collide_arm && bus.start[0]) begin
            rq[0] = 1'b1;
            collide_arm = 1'b0;
        end
        bus.src_tx_en = en;
        bus.src_txd   = d;
        bus.done      = dn;
        bus.req       = rq;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        compare();
        observe();
        engines();
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        n = 0;
        while ((m_owner >= 0 || m_pend != 0) && n < max) begin
            tick();
            n++;
        end
        check({"drained_", tag}, (m_owner >= 0 || m_pend != 0), 0);
        repeat (3) tick();
    endtask

    int cnt0;

    initial begin
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; done_pend[i] = 0; stuck[i] = 0;
        end
        bus.req = '0; bus.done = '0; bus.src_tx_en = '0; bus.src_txd = '0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Single request on engine 1, 64-byte frame.
        flen = 64;
        start_log.delete();
        bus.req = 3'b010;
        tick();
        tick();
        check("single_start_latency", bus.start, 3'b010);
        wait_idle("single", 300);
        check("single_nstarts", start_log.size(), 1);

        // Contention from a fresh reset: all three at once.
        rst = 1'b1; tick(); rst = 1'b0; tick();
        flen = 20;
        ifg_chk = 1'b1;
        start_log.delete();
        bus.req = 3'b111;
        tick();
        wait_idle("contention", 400);
        ifg_chk = 1'b0;
        check("cont_nstarts", start_log.size(), 3);
        if (start_log.size() == 3) begin
            check("cont_first", start_log[0], SRC_ARP);
            check("cont_second", start_log[1], SRC_ICMP);
            check("cont_third", start_log[2], SRC_UDP);
        end
        start_log.delete();
        bus.req = 3'b011;
        tick();
        wait_idle("wrap", 300);
        check("wrap_nstarts", start_log.size(), 2);
        if (start_log.size() > 0) check("wrap_first", start_log[0], SRC_ARP);

        // Isolation: engine 0 owns the port while the others make noise.
        noise = 1'b1;
        flen = 40;
        start_log.delete();
        bus.req = 3'b001;
        tick();
        wait_idle("isolation", 300);
        noise = 1'b0;
        check("iso_nstarts", start_log.size(), 1);

        // Re-request in the same cycle as start[0].
        flen = 10;
        start_log.delete();
        collide_arm = 1'b1;
        bus.req = 3'b001;
        tick();
        wait_idle("collide", 300);
        cnt0 = 0;
        foreach (start_log[k]) if (start_log[k] == 0) cnt0++;
        check("collide_two_starts", cnt0, 2);

        // Watchdog: engine 2 never reports done; engine 1 waits behind it.
        stuck[2] = 1'b1;
        flen = 8;
        n_timeout = 0;
        start_log.delete();
        bus.req = 3'b100;
        tick();
        repeat (5) tick();
        bus.req = 3'b010;
        tick();
        wait_idle("watchdog", 5000);
        stuck[2] = 1'b0;
        check("wd_pulses", n_timeout, 1);
        check("wd_nstarts", start_log.size(), 2);
        if (start_log.size() == 2) check("wd_next_served", start_log[1], SRC_ICMP);

        // Reset mid-frame with two requests pending.
        flen = 100;
        bus.req = 3'b001;
        tick();
        repeat (10) tick();
        bus.req = 3'b110;
        tick();
        tick();
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_grant", bus.grant, 0);
        check("rst_tx_en", gmii_tx_en, 0);
        start_log.delete();
        repeat (50) tick();
        check("rst_no_start", start_log.size(), 0);

        // Random traffic with noise and occasional resets.
        noise = 1'b1;
        flen = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) bus.req = 3'($urandom_range(1, 7));
            if ($urandom_range(0, 999) == 0) rst = 1'b1;
            tick();
            rst = 1'b0;
        end
        noise = 1'b0;
        wait_idle("random", 2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

endmodule
